// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - SimpleRisc IF stage: PC, imem drive, stall/redirect/halt handling
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_stalled/perf_flushed counters.
module fetch_pc_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              is_Branch_Taken,
  input  logic [31:0]       branchPC,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_ir,
  output logic              if_valid,
  output logic              flush_of,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalled,
  output logic [31:0]       perf_flushed
`endif
);

  localparam logic [31:0] NOP    = 32'h6800_0000;
  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_STALL, S_HALT} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_hold_ir;
  logic [31:0] w_word;
  logic [31:0] w_target;
  logic        w_present;
  logic        w_end;

  assign w_target  = branchPC & 32'hFFFF_FFFC;
  assign w_word    = (r_state == S_STALL) ? r_hold_ir : imem_rdata;
  assign w_present = (r_state == S_RUN) || (r_state == S_STALL);
  // End marker only counts when it would actually be consumed this cycle.
  assign w_end     = w_present && (w_word == MARKER) && !stall_in && !is_Branch_Taken;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (is_Branch_Taken) begin
      w_next_state = S_FILL;
    end else begin
      case (r_state)
        S_FILL:  w_next_state = S_RUN;
        S_RUN:   w_next_state = stall_in ? S_STALL : (w_end ? S_HALT : S_RUN);
        S_STALL: w_next_state = stall_in ? S_STALL : (w_end ? S_HALT : S_FILL);
        default: w_next_state = S_HALT;
      endcase
    end
  end

  always_comb begin
    imem_addr = r_fetch_pc[ADDR_W+1:2];
    if_pc     = r_out_pc;
    if_valid  = w_present && !is_Branch_Taken && !w_end;
    if_ir     = if_valid ? w_word : NOP;
    flush_of  = is_Branch_Taken;
    halted    = (r_state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= RESET_PC;
      r_hold_ir  <= NOP;
    end else if (is_Branch_Taken) begin
      r_fetch_pc <= w_target;
    end else begin
      case (r_state)
        S_FILL: begin
          r_out_pc   <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        S_RUN: begin
          if (stall_in) begin
            r_hold_ir <= imem_rdata;
          end else if (!w_end) begin
            r_out_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        S_STALL: begin
          // Re-read the successor so the word after the FILL bubble is fresh.
          if (!stall_in && !w_end) r_fetch_pc <= r_out_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
      perf_flushed <= '0;
    end else if (r_state != S_HALT) begin
      if (if_valid && !stall_in) perf_fetched <= perf_fetched + 32'd1;
      if (r_state == S_STALL)    perf_stalled <= perf_stalled + 32'd1;
      if (flush_of)              perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the SimpleRisc five-stage pipeline. Owns the program counter, drives the synchronous instruction memory and presents one instruction per cycle to the IF/OF latch, with the `pc`, `ir` and `valid` outputs aligned to the same instruction. Handles:
- OF interlock stalls;
- predict-not-taken redirects from the EX branch unit;
- end-of-program halt detection.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width (2^ADDR_W words).
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall_in`  in  1  interlock request from OF; hold the current output instruction.
- `is_Branch_Taken`  in  1  EX-stage taken branch/call/ret; squash wrong-path work.
- `branchPC`  in  32  redirect target byte address, valid with `is_Branch_Taken`.
- `imem_addr`  out  ADDR_W  word address to instruction memory (1-cycle read latency).
- `imem_rdata`  in  32  word returned for the address presented in the previous cycle.
- `if_pc`  out  32  byte PC of the instruction on `if_ir`.
- `if_ir`  out  32  instruction to the IF/OF latch; NOP (32'h6800_0000) when `if_valid`=0.
- `if_valid`  out  1  `if_ir` is a real in-order instruction.
- `flush_of`  out  1  one-cycle pulse: IF/OF latch must load a bubble (wrong-path squash).
- `halted`  out  1  end-of-program marker reached; fetch stopped.

## Operation
- Registers:
  - `fetch_pc`: address in flight to memory.
  - `out_pc`: PC of the word on `imem_rdata`.
  - `hold_ir`: captured word.
  - `state`.
- Address mapping: `imem_addr = fetch_pc[ADDR_W+1:2]`. `fetch_pc` advances by 4, modulo 2^32; `imem_addr` wraps modulo 2^ADDR_W.
- `branchPC[1:0]` is forced to 2'b00.
- States:
  - FILL: first cycle after reset or redirect; read in flight; `if_valid`=0. Next state is RUN.
  - RUN: present `imem_rdata` with `if_pc`=`out_pc` and `if_valid`=1.
    - Advance: `out_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4.
    - `stall_in`=1: capture `imem_rdata` into `hold_ir`, freeze both PCs, go to STALL.
  - STALL: present `hold_ir`/`out_pc` with `if_valid`=1.
    - Leave when `stall_in`=0.
    - The exit cycle re-issues `imem_addr` from `out_pc`+4 so that the next RUN word is correct. One bubble follows the exit cycle (`if_valid`=0), via FILL.
  - HALT: entered when a valid presented word equals 32'hFFFF_FFFF (loader end marker) with no stall and no branch.
    - The marker itself is not delivered: `if_valid`=0, `if_ir`=NOP.
    - `halted`=1; PCs frozen.
- Priority: `reset` > `is_Branch_Taken` > `stall_in` > halt detection.
- Redirect, in any state including STALL and HALT:
  - `fetch_pc`←`branchPC`, `flush_of`=1, `if_valid`=0 that cycle, `halted`←0, state←FILL.
  - The older in-flight instructions that caused the branch are downstream and unaffected.

## Timing
- Reset values:
  - `fetch_pc`=`out_pc`=`RESET_PC`, `hold_ir`=NOP, state=FILL.
  - `imem_addr`=`RESET_PC[ADDR_W+1:2]`.
  - `if_pc`=`RESET_PC`, `if_ir`=NOP, `if_valid`=0, `flush_of`=0, `halted`=0.
- Reset asserted mid-operation discards stall, redirect and halt state on the next edge.
- Latency:
  - First valid instruction appears 1 cycle after reset deassertion.
  - Steady throughput is 1 instruction per cycle.
- Redirect penalty: branch cycle plus FILL = 2 bubbles at `if_valid` from this unit.
- `flush_of` is asserted only in the cycle `is_Branch_Taken`=1. It is registered-free (combinational from `is_Branch_Taken`), not gated by state.
- `stall_in` asserted on consecutive cycles holds outputs bit-identical for the whole duration.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds three 32-bit outputs. All three reset to 0, wrap modulo 2^32, and are frozen in HALT.
  - `perf_fetched`: cycles with `if_valid`=1 and `stall_in`=0.
  - `perf_stalled`: cycles in STALL.
  - `perf_flushed`: `flush_of` pulses.
- When not defined, these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Sequential fetch:
  - Setup: memory words 0..3 = 0x0000_0001..0x0000_0004; release reset.
  - Required: cycle 1 `if_pc`=0/`if_ir`=1, then pc 4, 8, 12 on consecutive cycles, `if_valid`=1.
- Stall:
  - Stimulus: `stall_in`=1 for 3 cycles while pc 8 is presented.
  - Required: `if_pc`=8/`if_ir`=3 held for 3 cycles; one bubble; then pc 12.
- Redirect:
  - Stimulus: `is_Branch_Taken`=1 with `branchPC`=0x40 (plus 0x43 in a second run).
  - Required: `flush_of`=1 that cycle and 2 bubbles, then `if_pc`=0x40 with `if_ir`=mem[16].
- Branch during stall: `stall_in` and `is_Branch_Taken` both 1 → redirect wins, stall released, `if_pc`=target after 2 cycles.
- Halt:
  - Stimulus: word 5 = 0xFFFF_FFFF.
  - Required: pc 16 delivered, then `halted`=1 and `if_valid`=0 forever.
  - Stimulus: a later branch to 0.
  - Required: `halted`=0, then pc 0 refetched.
- Wrap and reset:
  - `ADDR_W`=2, run past word 3 → `imem_addr` wraps to 0 and `if_pc`=16.
  - Assert `reset` mid-stall → next cycle matches all reset values.
